// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
// Build option: define UART_TX_TWO_STOP_EN to send two stop bits per frame.
package uart_pkg;

    // Data bits per frame; the receiver uses the same constant.
    localparam int DATA_W = 8;

    // Width of the data-bit index inside a frame.
    localparam int IDX_W = $clog2(DATA_W);

`ifdef UART_TX_TWO_STOP_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif

    // Transmitter frame sequencer states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: bit-period counter for the UART transmitter.
// Counts 0..period-1 while enabled and pulses tick on the last count,
// which is the cycle on which the frame sequencer moves to the next bit.
module uart_tx_bit_timer #(
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               en,
    input  logic [PRESC_W-1:0] period,
    output logic               tick
);

    logic [PRESC_W-1:0] count_q;
    logic [PRESC_W-1:0] count_d;
    logic [PRESC_W-1:0] last_count;

    // Next count: wrap at the bit boundary, park at zero while idle.
    always_comb begin
        // NOTE: every signal gets a value before any branch so no latch is inferred.
        last_count = period - PRESC_W'(1);
        tick       = en && (count_q == last_count);
        count_d    = count_q + PRESC_W'(1);
        if (!en || tick) begin
            count_d = '0;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: flops are updated with non-blocking assignments so every register samples pre-edge values.
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: serial UART transmitter.
// Frame: start bit, DATA_W data bits LSB first, optional parity, stop bit(s);
// each bit lasts Prescale clocks (Prescale=0 behaves as 1).
// Build option: UART_TX_TWO_STOP_EN doubles the stop period (two stop bits).
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [DATA_W-1:0]  P_DATA,
    input  logic               Data_Valid,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic [PRESC_W-1:0] Prescale,
    output logic               TX_OUT,
    output logic               Busy
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    // Control state.
    tx_state_e          state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               tx_out_q, tx_out_d;
    logic               busy_q, busy_d;

    // Frame payload captured at accept.
    logic [DATA_W-1:0]  data_q, data_d;
    logic               par_en_q, par_en_d;
    logic               par_typ_q, par_typ_d;
    logic [PRESC_W-1:0] prescale_q, prescale_d;

    logic [PRESC_W-1:0] period;
    logic               bit_tick;
    logic               par_bit;
    logic [IDX_W-1:0]   idx_next;

    assign period   = (prescale_q == '0) ? PRESC_W'(1) : prescale_q;
    assign par_bit  = (^data_q) ^ par_typ_q;
    assign idx_next = idx_q + IDX_W'(1);

    uart_tx_bit_timer #(
        .PRESC_W (PRESC_W)
    ) u_bit_timer (
        .CLK    (CLK),
        .RST    (RST),
        .en     (state_q != IDLE),
        .period (period),
        .tick   (bit_tick)
    );

    // Frame sequencer: next state, bit index, line level and payload capture.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tx_out_d   = tx_out_q;
        busy_d     = busy_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        prescale_d = prescale_q;

        case (state_q)
            IDLE: begin
                tx_out_d = 1'b1;
                busy_d   = 1'b0;
                idx_d    = '0;
                if (Data_Valid) begin
                    data_d     = P_DATA;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    prescale_d = Prescale;
                    state_d    = START;
                    tx_out_d   = 1'b0;
                    busy_d     = 1'b1;
                end
            end

            START: begin
                if (bit_tick) begin
                    state_d  = DATA;
                    idx_d    = '0;
                    tx_out_d = data_q[0];
                end
            end

            DATA: begin
                if (bit_tick) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (par_en_q) begin
                            state_d  = PARITY;
                            tx_out_d = par_bit;
                        end else begin
                            state_d  = STOP;
                            tx_out_d = 1'b1;
                        end
                    end else begin
                        idx_d    = idx_next;
                        tx_out_d = data_q[idx_next];
                    end
                end
            end

            PARITY: begin
                if (bit_tick) begin
                    state_d  = STOP;
                    idx_d    = '0;
                    tx_out_d = 1'b1;
                end
            end

            STOP: begin
                if (bit_tick) begin
                    if (idx_q == STOP_LAST) begin
                        state_d  = IDLE;
                        idx_d    = '0;
                        busy_d   = 1'b0;
                        tx_out_d = 1'b1;
                    end else begin
                        idx_d = idx_next;
                    end
                end
            end

            default: begin
                state_d  = IDLE;
                idx_d    = '0;
                busy_d   = 1'b0;
                tx_out_d = 1'b1;
            end
        endcase
    end

    // Control registers; reset aborts any frame and returns the line to idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            tx_out_q <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tx_out_q <= tx_out_d;
            busy_q   <= busy_d;
        end
    end

    // Payload registers, loaded only when a frame is accepted.
    always_ff @(posedge CLK) begin
        // NOTE: payload registers carry no reset; they are always written at accept before being read.
        data_q     <= data_d;
        par_en_q   <= par_en_d;
        par_typ_q  <= par_typ_d;
        prescale_q <= prescale_d;
    end

    assign TX_OUT = tx_out_q;
    assign Busy   = busy_q;

endmodule
